mem_bus_arbiter: RTL and testbench

- Two-port arbiter that shares the single memory bus between the instruction cache (port I) and the data cache (port D).
- Each cache keeps its existing memory-side handshake: request (`read_mem`/`write_mem`), `grant_mem`, `ready_mem`.
- The arbiter picks one requester round-robin, registers its address, write data and operation, runs one memory transaction, and returns read data and ready.
- It sits between the cache pair and the memory model or SRAM controller.

---
 rtl/mem_bus_arbiter.sv | 114 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory bus between I-cache and D-cache ports
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_adbus,
  input  logic [31:0] i_wdata,
  output logic        i_grant,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_adbus,
  input  logic [31:0] d_wdata,
  output logic        d_grant,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_adbus,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic win, last, i_req, d_req, w_req, w_wr, pick, tmo;
  logic [TW-1:0] cnt;
  logic [31:0] rd_val;
  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;
  assign w_req = win ? d_req : i_req;
  assign w_wr = win ? d_write : i_write;
  // D wins a tie only when I was served last; a lone requester always wins
  assign pick = d_req & (~i_req | ~last);
  assign tmo = cnt == TW'(TIMEOUT - 1);
  assign rd_val = mem_ready ? mem_rdata : 32'hDEADBEEF;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (i_req | d_req) ? GRANT : IDLE;
      GRANT:   state_n = w_req ? ACCESS : IDLE;
      ACCESS:  state_n = (mem_ready | tmo) ? RESP : ACCESS;
      RESP:    state_n = w_req ? RESP : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      win <= 1'b0;
      last <= 1'b0;
      cnt <= '0;
      i_grant <= 1'b0;
      d_grant <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_adbus <= '0;
      mem_wdata <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        IDLE: if (i_req | d_req) begin
          win <= pick;
          i_grant <= ~pick;
          d_grant <= pick;
        end
        GRANT: if (w_req) begin
          mem_adbus <= win ? d_adbus : i_adbus;
          mem_wdata <= win ? d_wdata : i_wdata;
          mem_write <= w_wr;
          mem_read <= ~w_wr;
          cnt <= '0;
        end else begin
          i_grant <= 1'b0;
          d_grant <= 1'b0;
        end
        ACCESS: begin
          cnt <= cnt + TW'(1);
          if (mem_ready | tmo) begin
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            bus_error <= ~mem_ready;
            i_ready <= ~win;
            d_ready <= win;
            if (mem_read & win) d_rdata <= rd_val;
            if (mem_read & ~win) i_rdata <= rd_val;
          end
        end
        RESP: if (!w_req) begin
          i_grant <= 1'b0;
          d_grant <= 1'b0;
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          last <= win;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks against a transaction-level arbiter model
module tb_mem_bus_arbiter;
  localparam int TO = 4;
  localparam int W = 135;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] rd, wr, grant, ready, req;
  logic [31:0] adb [2];
  logic [31:0] wdt [2];
  logic [31:0] rdt [2];
  logic mread, mwrite, bus_error, mem_ready;
  logic [31:0] mem_adbus, mem_wdata, mem_rdata, mem_val;
  int mode, n_chk, n_fail, cnt;
  bit rand_on;
  always #5 clk = ~clk;
  assign req = rd | wr;
  mem_bus_arbiter #(.TIMEOUT(TO), .TW(3)) dut (
    .clk(clk), .reset(reset),
    .i_read(rd[0]), .i_write(wr[0]), .i_adbus(adb[0]), .i_wdata(wdt[0]),
    .i_grant(grant[0]), .i_ready(ready[0]), .i_rdata(rdt[0]),
    .d_read(rd[1]), .d_write(wr[1]), .d_adbus(adb[1]), .d_wdata(wdt[1]),
    .d_grant(grant[1]), .d_ready(ready[1]), .d_rdata(rdt[1]),
    .mem_read(mread), .mem_write(mwrite), .mem_adbus(mem_adbus), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_error(bus_error)
  );
  // Transaction-level model: an owner, edges spent since the grant, and a response flag
  logic [1:0] m_grant, m_ready;
  logic [31:0] m_rdata [2];
  logic m_mrd, m_mwr, m_err, busy, own, lst;
  logic [31:0] m_adbus, m_wdata;
  int age;
  always @(posedge clk) begin
    if (reset) begin
      busy = 0; own = 0; lst = 0; age = 0;
      m_grant = 0; m_ready = 0; m_rdata[0] = 0; m_rdata[1] = 0;
      m_mrd = 0; m_mwr = 0; m_adbus = 0; m_wdata = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (!busy) begin
        if (req != 0) begin
          own = (req == 2'b11) ? !lst : req[1];
          busy = 1; age = 0; m_grant[own] = 1;
        end
      end else if (age == 0) begin
        if (req[own]) begin
          m_mwr = wr[own]; m_mrd = !wr[own];
          m_adbus = adb[own]; m_wdata = wdt[own]; age = 1;
        end else begin
          m_grant[own] = 0; busy = 0;
        end
      end else if (!m_ready[own]) begin
        if (mem_ready || age == TO) begin
          if (m_mrd) m_rdata[own] = mem_ready ? mem_rdata : 32'hDEADBEEF;
          m_mrd = 0; m_mwr = 0; m_ready[own] = 1; m_err = !mem_ready;
        end
        age++;
      end else if (!req[own]) begin
        m_grant[own] = 0; m_ready[own] = 0; lst = own; busy = 0;
      end
    end
  end
  logic [W-1:0] outs, exp_outs;
  assign outs = {grant, ready, rdt[1], rdt[0], mread, mwrite, mem_adbus, mem_wdata, bus_error};
  assign exp_outs = {m_grant, m_ready, m_rdata[1], m_rdata[0], m_mrd, m_mwr, m_adbus, m_wdata, m_err};
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) check("cycle", outs, exp_outs);
  // Memory: 0 random, 1 answers one cycle after the op with mem_val, 2 silent, 3 always ready
  always @(negedge clk) begin
    mem_ready = (mode == 0) ? ($urandom % 3 == 0) : (mode == 1) ? (m_mrd | m_mwr) : (mode == 3);
    mem_rdata = (mode == 0) ? $urandom : mem_val;
  end
  always @(negedge clk) if (rand_on) begin
    reset = ($urandom % 256 == 0);
    for (int p = 0; p < 2; p++) begin
      if (!req[p]) begin
        if ($urandom % 4 == 0) begin
          cnt = $urandom_range(1, 3);
          rd[p] = cnt[0]; wr[p] = cnt[1];
        end
      end else if (m_ready[p] || $urandom % 16 == 0) begin
        rd[p] = 0; wr[p] = 0;
      end
      adb[p] = $urandom; wdt[p] = $urandom;
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wait_ready(input int p);
    for (int k = 0; k < 20 && !ready[p]; k++) tick();
    check("ready wait", W'(ready[p]), W'(1));
  endtask
  task automatic release_port(input int p);
    rd[p] = 0; wr[p] = 0;
    tick();
    check("grant drop", W'(grant[p]), W'(0));
    tick();
  endtask
  task automatic pulse_reset();
    reset = 1; tick(); reset = 0;
  endtask
  initial begin
    reset = 1; rd = 0; wr = 0; mode = 1; rand_on = 0; mem_val = 0;
    n_chk = 0; n_fail = 0;
    for (int p = 0; p < 2; p++) begin adb[p] = 0; wdt[p] = 0; end
    repeat (3) tick();
    check("reset state", outs, W'(0));
    reset = 0; mem_val = 32'hCAFE0001;
    rd[0] = 1; adb[0] = 32'h40;
    tick(); check("t1 grant", W'({grant, mread, mwrite}), W'(4'b0100));
    tick(); check("t1 op", W'({mread, mwrite, mem_adbus}), W'({2'b10, 32'h40}));
    tick(); check("t1 ready", W'({ready, rdt[1], rdt[0]}), W'({2'b01, 32'h0, 32'hCAFE0001}));
    release_port(0);
    pulse_reset();
    mem_val = 32'hA5A5_0002;
    rd[0] = 1; adb[0] = 32'h200; wr[1] = 1; adb[1] = 32'h100; wdt[1] = 32'h12345678;
    tick(); check("t2 d first", W'(grant), W'(2'b10));
    tick(); check("t2 write", W'({mwrite, mread, mem_adbus, mem_wdata}), W'({2'b10, 32'h100, 32'h12345678}));
    wait_ready(1);
    wr[1] = 0;
    tick(); wr[1] = 1;
    tick(); check("t2 i alternates", W'(grant), W'(2'b01));
    wait_ready(0);
    check("t2 i rdata", W'(rdt[0]), W'(32'hA5A5_0002));
    release_port(0);
    wait_ready(1);
    release_port(1);
    mode = 2;
    tick(); rd[1] = 1;
    tick(); tick();
    cnt = 0;
    while (mread && cnt < 10) begin cnt++; tick(); end
    check("t3 op edges", W'(cnt), W'(4));
    check("t3 timeout", W'({bus_error, ready, rdt[1]}), W'({3'b110, 32'hDEADBEEF}));
    tick(); check("t3 err pulse", W'({bus_error, ready}), W'(3'b010));
    release_port(1);
    mode = 1; mem_val = 32'h5555AAAA;
    tick(); rd[1] = 1;
    wait_ready(1);
    check("t3 recover", W'({bus_error, rdt[1]}), W'({1'b0, 32'h5555AAAA}));
    release_port(1);
    pulse_reset();
    rd[0] = 1;
    tick(); rd[0] = 0;
    tick(); check("t4 abort", W'({grant, mread, mwrite}), W'(0));
    rd[0] = 1; rd[1] = 1;
    tick(); check("t4 last kept", W'(grant), W'(2'b10));
    wait_ready(1); release_port(1);
    wait_ready(0); release_port(0);
    mode = 2; wr[0] = 1; adb[0] = 32'h300; wdt[0] = 32'h77;
    tick(); tick();
    check("t5 write busy", W'(mwrite), W'(1));
    reset = 1; wr[0] = 0;
    tick(); check("t5 reset mid", outs, W'(0));
    reset = 0; mode = 3;
    tick(); tick();
    check("t5 late ready", outs, W'(0));
    mode = 1; mem_val = 32'h11112222;
    tick(); rd[1] = 1;
    wait_ready(1);
    check("t6 read", W'(rdt[1]), W'(32'h11112222));
    release_port(1);
    mem_val = 32'h99999999; rd[1] = 1; wr[1] = 1;
    tick(); tick();
    check("t6 write wins", W'({mwrite, mread}), W'(2'b10));
    wait_ready(1);
    check("t6 rdata kept", W'(rdt[1]), W'(32'h11112222));
    release_port(1);
    mode = 0; rand_on = 1;
    repeat (4000) tick();
    rand_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
